// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if: writeback request bus, regfile write port and scoreboard signals
interface reg_wb_arbiter_if #(
   parameter int NREQ = 4,
   parameter int PW   = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [5*NREQ-1:0]    req_addr;
   logic [32*NREQ-1:0]   req_data;
   logic                 issue_valid;
   logic [4:0]           issue_addr;
   logic                 we3;
   logic [4:0]           a3;
   logic [31:0]          wd3;
   logic [PW-1:0]        wb_src;
   logic [31:0]          busy;
   modport master (
      output req_valid, req_addr, req_data, issue_valid, issue_addr,
      input  req_ready, we3, a3, wd3, wb_src, busy
   );
   modport slave (
      input  req_valid, req_addr, req_data, issue_valid, issue_addr,
      output req_ready, we3, a3, wd3, wb_src, busy
   );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin share of the regfile write port plus pending-write scoreboard
module reg_wb_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input logic             clk,
   input logic             reset,
   reg_wb_arbiter_if.slave bus
);
   logic [PW-1:0] ptr;
   logic [PW-1:0] grant;
   logic [PW-1:0] idx;
   logic          found;
   logic          xfer;
   logic [4:0]    g_addr;
   logic [31:0]   g_data;
   logic [31:0]   set_mask;
   logic [31:0]   clr_mask;
   // search from ptr upward; walking the offsets downward lets the nearest valid requester win
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end
   // pick the granted requester's address and data
   always_comb begin
      g_addr = '0;
      g_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (PW'(k) == grant) begin
            g_addr = bus.req_addr[5*k +: 5];
            g_data = bus.req_data[32*k +: 32];
         end
      end
   end
   assign xfer          = found & ~reset;
   assign bus.req_ready = xfer ? ({{(NREQ-1){1'b0}}, 1'b1} << grant) : '0;
   assign set_mask      = (bus.issue_valid ? (32'd1 << bus.issue_addr) : 32'd0) & ~32'd1;
   assign clr_mask      = bus.we3 ? (32'd1 << bus.a3) : 32'd0;
   // pointer, registered write port and scoreboard; a set beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         bus.we3    <= 1'b0;
         bus.a3     <= '0;
         bus.wd3    <= '0;
         bus.wb_src <= '0;
         bus.busy   <= '0;
      end else begin
         bus.we3  <= xfer && (g_addr != 5'd0);
         bus.busy <= (bus.busy & ~clr_mask) | set_mask;
         if (xfer) begin
            ptr        <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
            bus.a3     <= g_addr;
            bus.wd3    <= g_data;
            bus.wb_src <= grant;
         end
      end
   end
endmodule
